// File: rtl/br_update_queue_if.sv
//------------------------------------------------------------------------------
// Module  : br_update_queue_if
// Brief   : Allocation, resolution and predictor-update signals of the branch
//           update queue, with driver (master) and queue-side (slave) views.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface br_update_queue_if #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 32,
    parameter int CNT_W = 16
);
    localparam int c_OCC_W = $clog2(DEPTH) + 1;

    logic               alloc_valid_i;
    logic [IDX_W-1:0]   alloc_idx_i;
    logic               alloc_pred_i;
    logic               alloc_ready_o;
    logic               resolve_valid_i;
    logic               resolve_taken_i;
    logic               flush_i;
    logic               update_en_o;
    logic               br_result_o;
    logic               correct_o;
    logic [IDX_W-1:0]   idx_o;
    logic [c_OCC_W-1:0] count_o;
    logic [CNT_W-1:0]   mispredict_cnt_o;
    logic               underflow_err_o;
    logic               overflow_err_o;

    modport master (
        output alloc_valid_i, alloc_idx_i, alloc_pred_i,
        output resolve_valid_i, resolve_taken_i, flush_i,
        input  alloc_ready_o, update_en_o, br_result_o, correct_o, idx_o,
        input  count_o, mispredict_cnt_o, underflow_err_o, overflow_err_o
    );

    modport slave (
        input  alloc_valid_i, alloc_idx_i, alloc_pred_i,
        input  resolve_valid_i, resolve_taken_i, flush_i,
        output alloc_ready_o, update_en_o, br_result_o, correct_o, idx_o,
        output count_o, mispredict_cnt_o, underflow_err_o, overflow_err_o
    );
endinterface

`default_nettype wire

// File: rtl/br_update_queue.sv
//------------------------------------------------------------------------------
// Module  : br_update_queue
// Brief   : In-order queue pairing branch predictions with their resolved
//           outcomes and driving the predictor update port one cycle later.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module br_update_queue #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    br_update_queue_if.slave  bus
);
    localparam int                 c_PTR_W   = $clog2(DEPTH);
    localparam int                 c_OCC_W   = c_PTR_W + 1;
    localparam logic [c_OCC_W-1:0] c_FULL    = c_OCC_W'(DEPTH);
    localparam logic [c_OCC_W-1:0] c_OCC_ONE = c_OCC_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [CNT_W-1:0]   c_CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0]   c_CNT_MAX = '1;

    logic [IDX_W-1:0]   r_idx_mem [DEPTH];
    logic [DEPTH-1:0]   r_pred_mem;
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_OCC_W-1:0] r_count;
    logic               r_update_en;
    logic               r_br_result;
    logic               r_correct;
    logic [IDX_W-1:0]   r_idx_out;
    logic [CNT_W-1:0]   r_mispred_cnt;
    logic               r_underflow;
    logic               r_overflow;

    logic               w_full;
    logic               w_empty;
    logic               w_do_alloc;
    logic               w_do_resolve;
    logic               w_mispred;
    logic [c_PTR_W-1:0] w_head_nxt;
    logic [c_PTR_W-1:0] w_tail_nxt;
    logic [c_OCC_W-1:0] w_count_nxt;

    assign w_full       = (r_count == c_FULL);
    assign w_empty      = (r_count == '0);
    // Ready looks only at the registered count, so a same-cycle pop never frees a slot.
    assign w_do_alloc   = bus.alloc_valid_i && !w_full && !bus.flush_i;
    assign w_do_resolve = bus.resolve_valid_i && !w_empty;
    assign w_mispred    = (r_pred_mem[r_head] != bus.resolve_taken_i);

    always_comb begin
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        w_count_nxt = r_count;
        if (w_do_resolve) begin
            w_head_nxt = r_head + c_PTR_ONE;
        end
        // Flush is applied after the pop so the resolving entry still reports.
        if (bus.flush_i) begin
            w_tail_nxt  = w_head_nxt;
            w_count_nxt = '0;
        end else begin
            if (w_do_alloc) begin
                w_tail_nxt = r_tail + c_PTR_ONE;
            end
            if (w_do_alloc && !w_do_resolve) begin
                w_count_nxt = r_count + c_OCC_ONE;
            end else if (!w_do_alloc && w_do_resolve) begin
                w_count_nxt = r_count - c_OCC_ONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_do_alloc) begin
            r_idx_mem[r_tail]  <= bus.alloc_idx_i;
            r_pred_mem[r_tail] <= bus.alloc_pred_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_update_en   <= 1'b0;
            r_br_result   <= 1'b0;
            r_correct     <= 1'b0;
            r_idx_out     <= '0;
            r_mispred_cnt <= '0;
            r_underflow   <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_head      <= w_head_nxt;
            r_tail      <= w_tail_nxt;
            r_count     <= w_count_nxt;
            r_update_en <= w_do_resolve;
            if (w_do_resolve) begin
                r_idx_out   <= r_idx_mem[r_head];
                r_br_result <= bus.resolve_taken_i;
                r_correct   <= !w_mispred;
                if (w_mispred && (r_mispred_cnt != c_CNT_MAX)) begin
                    r_mispred_cnt <= r_mispred_cnt + c_CNT_ONE;
                end
            end
            if (bus.resolve_valid_i && w_empty) begin
                r_underflow <= 1'b1;
            end
            if (bus.alloc_valid_i && w_full && !bus.flush_i) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign bus.alloc_ready_o    = !w_full;
    assign bus.update_en_o      = r_update_en;
    assign bus.br_result_o      = r_br_result;
    assign bus.correct_o        = r_correct;
    assign bus.idx_o            = r_idx_out;
    assign bus.count_o          = r_count;
    assign bus.mispredict_cnt_o = r_mispred_cnt;
    assign bus.underflow_err_o  = r_underflow;
    assign bus.overflow_err_o   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_br_update_queue.sv
//------------------------------------------------------------------------------
// Module  : tb_br_update_queue
// Brief   : Scoreboard bench for br_update_queue against a queue-based model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_br_update_queue;
    localparam int DEPTH   = 8;
    localparam int IDX_W   = 32;
    localparam int CNT_W   = 2;
    localparam int MIS_MAX = (1 << CNT_W) - 1;

    typedef struct {
        logic [IDX_W-1:0] idx;
        logic             pred;
    } ent_t;

    typedef struct {
        logic [IDX_W-1:0] idx;
        logic             br;
        logic             corr;
    } upd_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    br_update_queue_if #(.DEPTH(DEPTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

    br_update_queue #(.DEPTH(DEPTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    int checks = 0;
    int passed = 0;

    // Reference model: a plain queue of outstanding predictions
    ent_t             mq[$];
    upd_t             exp_q[$];
    bit               m_pulse = 0;
    bit               m_under = 0;
    bit               m_over  = 0;
    int               m_mis   = 0;
    logic [IDX_W-1:0] m_idx   = '0;
    logic             m_br    = 1'b0;
    logic             m_corr  = 1'b0;
    int               m_size;
    ent_t             m_e;
    upd_t             m_u;

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            exp_q.delete();
            m_pulse = 0; m_under = 0; m_over = 0; m_mis = 0;
            m_idx = '0; m_br = 1'b0; m_corr = 1'b0;
        end else begin
            m_size  = mq.size();
            m_pulse = 0;
            if (bus.resolve_valid_i) begin
                if (m_size == 0) begin
                    m_under = 1;
                end else begin
                    m_e    = mq.pop_front();
                    m_u.idx  = m_e.idx;
                    m_u.br   = bus.resolve_taken_i;
                    m_u.corr = (m_e.pred == bus.resolve_taken_i);
                    exp_q.push_back(m_u);
                    m_pulse = 1;
                    m_idx = m_u.idx; m_br = m_u.br; m_corr = m_u.corr;
                    if (!m_u.corr && m_mis < MIS_MAX) m_mis++;
                end
            end
            if (bus.flush_i) begin
                mq.delete();
            end else if (bus.alloc_valid_i) begin
                if (m_size == DEPTH) begin
                    m_over = 1;
                end else begin
                    m_e.idx  = bus.alloc_idx_i;
                    m_e.pred = bus.alloc_pred_i;
                    mq.push_back(m_e);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        else passed++;
    endtask

    // Monitor: state outputs every cycle, update pulses popped from the scoreboard
    upd_t mon_u;
    always @(negedge clk) begin
        chk("count", 64'(bus.count_o), 64'(mq.size()));
        chk("alloc_ready", 64'(bus.alloc_ready_o), 64'(mq.size() != DEPTH));
        chk("underflow", 64'(bus.underflow_err_o), 64'(m_under));
        chk("overflow", 64'(bus.overflow_err_o), 64'(m_over));
        chk("mispredict_cnt", 64'(bus.mispredict_cnt_o), 64'(m_mis));
        chk("update_en", 64'(bus.update_en_o), 64'(m_pulse));
        if (bus.update_en_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL update_unexpected: got pulse expected none at %0t", $time);
            end else begin
                mon_u = exp_q.pop_front();
                chk("upd_idx", 64'(bus.idx_o), 64'(mon_u.idx));
                chk("upd_br", 64'(bus.br_result_o), 64'(mon_u.br));
                chk("upd_correct", 64'(bus.correct_o), 64'(mon_u.corr));
            end
        end else begin
            chk("hold_idx", 64'(bus.idx_o), 64'(m_idx));
            chk("hold_br", 64'(bus.br_result_o), 64'(m_br));
            chk("hold_correct", 64'(bus.correct_o), 64'(m_corr));
        end
    end

    task automatic drive(input bit av, input logic [IDX_W-1:0] ai, input bit ap,
                         input bit rv, input bit rt, input bit fl, input bit rn);
        @(negedge clk);
        bus.alloc_valid_i   = av;
        bus.alloc_idx_i     = ai;
        bus.alloc_pred_i    = ap;
        bus.resolve_valid_i = rv;
        bus.resolve_taken_i = rt;
        bus.flush_i         = fl;
        rst_n               = rn;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, '0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.alloc_valid_i = 0; bus.alloc_idx_i = '0; bus.alloc_pred_i = 0;
        bus.resolve_valid_i = 0; bus.resolve_taken_i = 0; bus.flush_i = 0;
        drive(0, '0, 0, 0, 0, 0, 0);
        idle(1);

        // Single alloc, resolved three cycles later
        drive(1, 32'h40, 1, 0, 0, 0, 1);
        idle(2);
        drive(0, '0, 0, 1, 1, 0, 1);
        idle(2);

        // Fill, overflow attempt, drain
        for (int i = 0; i < DEPTH; i++) drive(1, i, $urandom_range(0, 1), 0, 0, 0, 1);
        drive(1, 32'h99, 1, 0, 0, 0, 1);
        for (int i = 0; i < DEPTH; i++) drive(0, '0, 0, 1, $urandom_range(0, 1), 0, 1);
        idle(2);

        // Pointer wrap
        for (int i = 0; i < 6; i++) drive(1, 32'h100 + i, 0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) drive(0, '0, 0, 1, 0, 0, 1);
        for (int i = 0; i < 6; i++) drive(1, 32'h200 + i, 1, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) drive(0, '0, 0, 1, 1, 0, 1);
        idle(1);

        // Resolve while empty with a same-cycle alloc
        drive(1, 32'h55, 0, 1, 1, 0, 1);
        idle(1);
        drive(0, '0, 0, 1, 0, 0, 1);

        // Resolve and flush together, then resolve on the empty queue
        for (int i = 0; i < 3; i++) drive(1, 32'h300 + i, 1, 0, 0, 0, 1);
        drive(1, 32'h3ff, 1, 1, 1, 1, 1);
        drive(0, '0, 0, 1, 1, 0, 1);
        idle(1);

        // Mispredict saturation, then reset with a resolve in flight
        drive(0, '0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) drive(1, 32'h400 + i, 1, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) drive(0, '0, 0, 1, 0, 0, 1);
        drive(0, '0, 0, 1, 0, 0, 0);
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 99) < 55, $urandom, $urandom_range(0, 1),
                  $urandom_range(0, 99) < 45, $urandom_range(0, 1),
                  $urandom_range(0, 99) < 4, $urandom_range(0, 299) != 0);
        end
        idle(3);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

`default_nettype wire
